pipeline_register_elastic: RTL and testbench

//  Parametrised successor to the fixed per-stage pipeline registers (if_id, id_ex, ex_mem, mem_wb).

---
 rtl/pipeline_register_elastic.sv | 165 ++++++++++++++++
 tb/tb_pipeline_register_elastic.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_register_elastic.sv
// pipeline_register_elastic
//   Elastic pipeline stage carrying CTRL_W control bits plus DATA_W payload
//   over a valid/ready handshake. It holds two entries: a main register that
//   drives the outputs and a skid register. With two entries the stage keeps
//   full throughput while in_ready stays a flop, so there is no combinational
//   path from out_ready to in_ready.
//   flush drops every held entry and puts a bubble (BUBBLE_CTRL) on out_ctrl.
//   It does not reset the datapath: out_data keeps its last value.
//
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   flush      in   1       synchronous flush; beats any transfer in the same cycle
//   in_valid   in   1       upstream entry valid
//   in_ready   out  1       stage can accept (registered)
//   in_ctrl    in   CTRL_W  upstream control bits
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       downstream entry valid
//   out_ready  in   1       downstream accepts
//   out_ctrl   out  CTRL_W  control to next stage; BUBBLE_CTRL while out_valid=0
//   out_data   out  DATA_W  payload to next stage; holds its last value while empty
//   stall_cnt  out  CNT_W   cycles with out_valid & !out_ready (saturating)
//   flush_cnt  out  CNT_W   cycles in which flush dropped >=1 entry (saturating)
//
// Build option
//   PIPE_STAGE_PERF_EN: when defined, stall_cnt/flush_cnt and their counters
//   are present. When undefined, those ports and counters are absent and the
//   handshake behaves the same.

module pipeline_register_elastic #(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        CTRL_W      = 25,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Reject degenerate widths at elaboration time.
    if (DATA_W == 0 || CTRL_W == 0 || CNT_W == 0) begin : g_param_check
        $error("pipeline_register_elastic: DATA_W, CTRL_W and CNT_W must be non-zero");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]  out_ctrl_d;
    logic [DATA_W-1:0]  out_data_d;
    logic               out_valid_d;
    logic               in_ready_d;

    // State and datapath registers. out_ctrl/out_data are the main entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            out_ctrl    <= BUBBLE_CTRL;
            out_data    <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            state_q     <= state_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_ctrl    <= out_ctrl_d;
            out_data    <= out_data_d;
            out_valid   <= out_valid_d;
            in_ready    <= in_ready_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d     = state_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        out_ctrl_d  = out_ctrl;
        out_data_d  = out_data;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d    = ST_BUSY;
                        out_ctrl_d = in_ctrl;
                        out_data_d = in_data;
                    end
                end
                ST_BUSY: begin
                    if (in_valid && out_ready) begin
                        out_ctrl_d = in_ctrl;
                        out_data_d = in_data;
                    end else if (in_valid) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so in_valid is ignored.
                    if (out_ready) begin
                        state_d    = ST_BUSY;
                        out_ctrl_d = skid_ctrl_q;
                        out_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);

        // While empty, downstream decode sees a NOP. out_data keeps its last value.
        if (!out_valid_d) begin
            out_ctrl_d = BUBBLE_CTRL;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating performance counters. Only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (state_q != ST_EMPTY) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_register_elastic.sv
// Self-checking bench for pipeline_register_elastic. A queue-based reference
// model predicts every output each cycle. Directed scenarios are followed by
// randomized handshake traffic.
module tb_pipeline_register_elastic;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 25;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ENT_W  = CTRL_W + DATA_W;
    localparam logic [CTRL_W-1:0] BUB = 25'h0A5_A5A5;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    pipeline_register_elastic #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .BUBBLE_CTRL (BUB),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two {ctrl,data} entries.
    logic [ENT_W-1:0]  q[$];
    logic [DATA_W-1:0] m_last_data;
    int                m_stall;
    int                m_flush;
    int                n_cmp;
    int                n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last_data = '0;
        m_stall     = 0;
        m_flush     = 0;
    endtask

    task automatic check_all(input string tag);
        logic [CTRL_W-1:0] exp_ctrl;
        exp_ctrl = (q.size() > 0) ? q[0][ENT_W-1:DATA_W] : BUB;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
        chk({tag, ".out_ctrl"},  64'(out_ctrl),  64'(exp_ctrl));
        chk({tag, ".out_data"},  64'(out_data),  64'(m_last_data));
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // Advance the model by one clock from the current inputs, then check outputs.
    task automatic step(input string tag);
        int               n;
        int               sat;
        logic [ENT_W-1:0] ent;
        n   = q.size();
        sat = (1 << CNT_W) - 1;
        ent = {in_ctrl, in_data};
        if (n > 0 && !out_ready && m_stall < sat) m_stall++;
        if (flush) begin
            if (n > 0 && m_flush < sat) m_flush++;
            q.delete();
        end else begin
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2) q.push_back(ent);
        end
        if (q.size() > 0) m_last_data = q[0][DATA_W-1:0];
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = CTRL_W'(d) ^ 25'h1F0_0001;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter saturation, then a flush of a busy stage.
        drive(1'b1, 32'h1, 1'b0, 1'b0);
        step("perf_fill");
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step("perf_stall");
        chk("perf_stall_sat", 64'(stall_cnt), 64'd7);
        drive(1'b0, '0, 1'b0, 1'b1);
        step("perf_flush");
        chk("perf_flush_one", 64'(flush_cnt), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        step("perf_idle");
`endif

        // Back-to-back streaming at full throughput.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DATA_W'(32'h10 + i), 1'b1, 1'b0);
            step("stream");
            chk("stream_data", 64'(out_data), 64'(32'h10 + i));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step("stream_drain");

        // Fill the skid register, then drain in order.
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step("skid_a");
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step("skid_b");
        chk("skid_hold_a", 64'(out_data), 64'hA);
        chk("skid_full", 64'(in_ready), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        step("skid_pop_a");
        chk("skid_then_b", 64'(out_data), 64'hB);
        step("skid_pop_b");
        chk("skid_empty", 64'(out_valid), 64'd0);

        // Flush a full stage while an input is offered.
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step("fl_a");
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step("fl_b");
        drive(1'b1, 32'hC, 1'b1, 1'b1);
        step("fl_flush");
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("fl_ready", 64'(in_ready), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("fl_after");

        // Asynchronous reset in the middle of a cycle while full.
        drive(1'b1, 32'h21, 1'b0, 1'b0);
        step("rst_a");
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        step("rst_b");
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("arst_data", 64'(out_data), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        step("arst_idle");

        // Randomized traffic in phases with different valid/ready bias.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                logic v, r, f;
                v = (ph == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                r = (ph == 2) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                f = ($urandom_range(0, 31) == 0);
                drive(v, DATA_W'($urandom), r, f);
                step("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
